// File: rtl/mnasser_mult_pkg.sv
// mnasser_mult_pkg
// Shared constants for the TT03 demo multiplier sequencer:
//   - OP_W_DEF : operand width (product is 2*OP_W_DEF bits)
//   - ST_*     : sequencer state encoding
//   - DIG_*    : product digit indices shown on the 7-segment display
//   - prod_digit() : selects one hex digit of the (zero-extended) product
package mnasser_mult_pkg;

  localparam int OP_W_DEF = 5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT_B = 2'd1;
  localparam state_t ST_MULT   = 2'd2;
  localparam state_t ST_SHOW   = 2'd3;

  localparam logic [1:0] DIG_MS = 2'd2;
  localparam logic [1:0] DIG_LS = 2'd0;

  // Digit 2 only carries the top two product bits; the upper nibble bits
  // come from zero extension of the 10-bit product.
  function automatic logic [3:0] prod_digit(input logic [11:0] p, input logic [1:0] dig);
    logic [3:0] nib;
    case (dig)
      2'd0:    nib = p[3:0];
      2'd1:    nib = p[7:4];
      default: nib = p[11:8];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/mnasser_shiftadd_core.sv
// mnasser_shiftadd_core
// Sequential shift-add multiplier, one multiplier bit per cycle.
//   clk, reset : clock, synchronous active-high reset
//   load_a     : capture a_in as multiplicand A
//   start      : one-cycle pulse; captures b_in as B, clears P, begins OP_W adds
//   done       : one-cycle pulse during the last add (P final on the next edge)
//   p          : registered product
//   p_next     : product value that will be registered on the next edge
module mnasser_shiftadd_core
  import mnasser_mult_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_a,
  input  logic              start,
  input  logic [OP_W-1:0]   a_in,
  input  logic [OP_W-1:0]   b_in,
  output logic              done,
  output logic [2*OP_W-1:0] p,
  output logic [2*OP_W-1:0] p_next
);

  localparam int CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;

  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*OP_W-1:0] p_q, p_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done      = 1'b0;
    if (load_a) begin
      a_d = a_in;
    end
    if (start) begin
      b_d       = b_in;
      p_d       = '0;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      if (b_q[bit_cnt_q]) begin
        p_d = p_q + ({{OP_W{1'b0}}, a_q} << bit_cnt_q);
      end
      if (bit_cnt_q == CNT_W'(OP_W - 1)) begin
        done      = 1'b1;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign p      = p_q;
  assign p_next = p_d;

endmodule

// File: rtl/seg7.sv
// seg7
// Hex nibble to 7-segment decoder (active-high, bit order {g,f,e,d,c,b,a}).
//   counter  : nibble to show
//   segments : segment pattern
module seg7 (
  input  logic [3:0] counter,
  output logic [6:0] segments
);

  always_comb begin
    case (counter)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      default: segments = 7'h71;
    endcase
  end

endmodule

// File: rtl/mnasser_mult_seq.sv
// mnasser_mult_seq
// TT03 demo multiplier sequencer: captures operand A then B on rising strobe
// edges, multiplies them over OP_W cycles, then cycles the product's hex
// digits (MS first) on the seven-segment display, DWELL cycles each.
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   op_in  : [4:0] operand value, [5] strobe
//   seg    : seven-segment pattern of the displayed nibble
//   mark   : high while multiplying and while the MS product digit is shown
// Build option: define MNASSER_MULT_DEBOUNCE_EN to require DEB_CYC consecutive
// equal samples before the strobe is considered to have changed.
module mnasser_mult_seq
  import mnasser_mult_pkg::*;
#(
  parameter int DWELL   = 1000,
  parameter int DEB_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_in,
  output logic [6:0] seg,
  output logic       mark
);

  localparam int OP_W    = OP_W_DEF;
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  // ---------------- input stage ----------------
  logic [OP_W-1:0] val_s_q, val_s_d;
  logic            strobe_s_q, strobe_s_d, strobe_d_q;
  logic            armed_q, armed_d;
  logic            edge_s;

`ifdef MNASSER_MULT_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // Count consecutive samples disagreeing with the current strobe level; the
  // level flips on the DEB_CYC-th one, and a rising flip latches that sample's value.
  always_comb begin
    val_s_d    = val_s_q;
    strobe_s_d = strobe_s_q;
    deb_cnt_d  = '0;
    if (op_in[5] != strobe_s_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYC - 1)) begin
        strobe_s_d = op_in[5];
        if (op_in[5]) begin
          val_s_d = op_in[OP_W-1:0];
        end
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
    end
  end
`else
  always_comb begin
    val_s_d    = op_in[OP_W-1:0];
    strobe_s_d = op_in[5];
  end
`endif

  // armed blocks the false edge a strobe held high through reset release
  // would otherwise produce; it is set once the strobe has been seen low.
  assign armed_d = armed_q | ~strobe_s_d;
  assign edge_s  = strobe_s_q & ~strobe_d_q & armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      val_s_q    <= '0;
      strobe_s_q <= 1'b0;
      strobe_d_q <= 1'b0;
      armed_q    <= ~op_in[5];
    end else begin
      val_s_q    <= val_s_d;
      strobe_s_q <= strobe_s_d;
      strobe_d_q <= strobe_s_q;
      armed_q    <= armed_d;
    end
  end

  // ---------------- multiplier core ----------------
  logic              load_a, start, done;
  logic [2*OP_W-1:0] p, p_next;

  mnasser_shiftadd_core #(.OP_W(OP_W)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load_a (load_a),
    .start  (start),
    .a_in   (val_s_q),
    .b_in   (val_s_q),
    .done   (done),
    .p      (p),
    .p_next (p_next)
  );

  // ---------------- sequencer ----------------
  state_t               state_q, state_d;
  logic [3:0]           disp_nib_q, disp_nib_d;
  logic [1:0]           digit_q, digit_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;

  always_comb begin
    state_d     = state_q;
    disp_nib_d  = disp_nib_q;
    digit_d     = digit_q;
    dwell_cnt_d = dwell_cnt_q;
    load_a      = 1'b0;
    start       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        disp_nib_d = 4'd0;
        if (edge_s) begin
          load_a     = 1'b1;
          disp_nib_d = val_s_q[3:0];
          state_d    = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (edge_s) begin
          start   = 1'b1;
          state_d = ST_MULT;
        end
      end
      ST_MULT: begin
        // Edges are ignored here. p_next carries the final product on the
        // done cycle so the MS digit is visible on the first SHOW cycle.
        if (done) begin
          state_d     = ST_SHOW;
          digit_d     = DIG_MS;
          dwell_cnt_d = '0;
          disp_nib_d  = prod_digit(12'(p_next), DIG_MS);
        end
      end
      default: begin // ST_SHOW
        if (edge_s) begin
          load_a      = 1'b1;
          disp_nib_d  = val_s_q[3:0];
          digit_d     = '0;
          dwell_cnt_d = '0;
          state_d     = ST_WAIT_B;
        end else begin
          if (dwell_cnt_q == DWELL_W'(DWELL - 1)) begin
            dwell_cnt_d = '0;
            digit_d     = (digit_q == DIG_LS) ? DIG_MS : digit_q - 2'd1;
          end else begin
            dwell_cnt_d = dwell_cnt_q + 1'b1;
          end
          disp_nib_d = prod_digit(12'(p), digit_d);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      disp_nib_q  <= 4'd0;
      digit_q     <= '0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      disp_nib_q  <= disp_nib_d;
      digit_q     <= digit_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign mark = (state_q == ST_MULT) || ((state_q == ST_SHOW) && (digit_q == DIG_MS));

  seg7 u_seg7 (
    .counter  (disp_nib_q),
    .segments (seg)
  );

endmodule

// File: tb/tb_mnasser_mult_seq.sv
// tb_mnasser_mult_seq
// Scoreboard bench: stimulus pushes cycle-tagged expected {nibble, mark}
// pairs; a monitor pops and compares them at the falling edge of that cycle.
module tb_mnasser_mult_seq;

  localparam int D = 6;
`ifdef MNASSER_MULT_DEBOUNCE_EN
  localparam int PW  = 4;
  localparam int LAT = 5;
`else
  localparam int PW  = 1;
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op_in;
  logic [6:0] seg;
  logic       mark;

  mnasser_mult_seq #(.DWELL(D), .DEB_CYC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .op_in (op_in),
    .seg   (seg),
    .mark  (mark)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] nib;
    logic       mk;
    string      name;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [6:0] seg7_ref(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  task automatic expect_at(input int c, input logic [3:0] nib, input logic mk, input string nm);
    exp_t e;
    e.c = c; e.nib = nib; e.mk = mk; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].c <= cyc) begin
        exp_t e;
        e = q.pop_front();
        n_chk++;
        if (e.c < cyc) begin
          n_fail++;
          $display("FAIL %s: check for cycle %0d missed (now cycle %0d)", e.name, e.c, cyc);
        end else if (seg !== seg7_ref(e.nib) || mark !== e.mk) begin
          n_fail++;
          $display("FAIL %s @%0d: seg=%h mark=%b, required seg=%h (nib %h) mark=%b",
                   e.name, cyc, seg, mark, seg7_ref(e.nib), e.nib, e.mk);
        end else begin
          $display("ok   %s @%0d: seg=%h mark=%b", e.name, cyc, seg, mark);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic strobe_on(input logic [4:0] v, output int k);
    op_in = {1'b1, v};
    k = cyc;
  endtask

  task automatic strobe_off();
    step(PW);
    op_in[5] = 1'b0;
    step(PW + 1);
  endtask

  // Expectations for a B strobe issued at cycle k with multiplicand nibble a.
  task automatic expect_product(input int k, input logic [3:0] a,
                                input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    int s;
    s = k + LAT + 5;
    expect_at(k + LAT - 1, a, 1'b0, "waitb_hold");
    expect_at(k + LAT,     a, 1'b1, "mult_first");
    expect_at(k + LAT + 4, a, 1'b1, "mult_last");
    expect_at(s,             d2, 1'b1, "dig2");
    expect_at(s + D - 1,     d2, 1'b1, "dig2_end");
    expect_at(s + D,         d1, 1'b0, "dig1");
    expect_at(s + 2*D,       d0, 1'b0, "dig0");
    expect_at(s + 3*D - 1,   d0, 1'b0, "dig0_end");
    expect_at(s + 3*D,       d2, 1'b1, "dig2_wrap");
  endtask

  int k, c;

  initial begin
    reset = 1'b1;
    op_in = 6'd0;
    step(2);
    expect_at(cyc, 4'd0, 1'b0, "reset");
    reset = 1'b0;
    expect_at(cyc + 1, 4'd0, 1'b0, "idle");

    // A = 5
    strobe_on(5'd5, k);
    expect_at(k + LAT - 1, 4'd0, 1'b0, "idle_pre_edge");
    expect_at(k + LAT,     4'd5, 1'b0, "capA_5");
    strobe_off();

    // B = 7 -> 35 = 0x023
    strobe_on(5'd7, k);
    expect_product(k, 4'd5, 4'd0, 4'd2, 4'd3);
    strobe_off();
    wait_until(k + LAT + 5 + 3*D + 1);

    // A = 31 (strobe in SHOW), B = 31 -> 961 = 0x3C1
    strobe_on(5'd31, k);
    expect_at(k + LAT, 4'hF, 1'b0, "capA_31");
    strobe_off();
    strobe_on(5'd31, k);
    expect_product(k, 4'hF, 4'h3, 4'hC, 4'h1);
    strobe_off();
    wait_until(k + LAT + 5 + 3*D + 1);

    // A = 0, B = 31 -> 0
    strobe_on(5'd0, k);
    expect_at(k + LAT, 4'h0, 1'b0, "capA_0");
    strobe_off();
    strobe_on(5'd31, k);
    expect_product(k, 4'h0, 4'h0, 4'h0, 4'h0);
    strobe_off();
    wait_until(k + LAT + 5 + 3*D + 1);

    // A = 5, B = 7 with an extra strobe during MULT
    strobe_on(5'd5, k);
    expect_at(k + LAT, 4'd5, 1'b0, "capA_5b");
    strobe_off();
    strobe_on(5'd7, k);
    expect_product(k, 4'd5, 4'd0, 4'd2, 4'd3);
`ifndef MNASSER_MULT_DEBOUNCE_EN
    step(1);
    op_in[5] = 1'b0;
    step(2);
    op_in = {1'b1, 5'd9};   // edge lands in MULT
    step(1);
    op_in[5] = 1'b0;
    step(2);
`else
    strobe_off();
`endif
    wait_until(k + LAT + 5 + 3*D + 1);

    // Strobe during SHOW abandons the display
    strobe_on(5'd10, k);
    expect_at(k + LAT,     4'hA, 1'b0, "show_abort");
    expect_at(k + LAT + 3, 4'hA, 1'b0, "waitb_newA");
    strobe_off();
    wait_until(k + LAT + 4);

    // Reset on the 3rd MULT cycle, strobe held high through reset release
    strobe_on(5'd3, k);
    expect_at(k + LAT + 2, 4'hA, 1'b1, "mult3");
    step(PW);
    op_in[5] = 1'b0;
    wait_until(k + LAT + 2);
    reset = 1'b1;
    op_in = {1'b1, 5'd9};
    expect_at(k + LAT + 3, 4'd0, 1'b0, "reset_mid_mult");
    step(2);
    reset = 1'b0;
    c = cyc;
    expect_at(c + LAT + 2, 4'd0, 1'b0, "held_nocap");
    expect_at(c + 10,      4'd0, 1'b0, "held_nocap2");
    wait_until(c + 11);
    op_in[5] = 1'b0;
    step(PW + 1);
    strobe_on(5'd3, k);
    expect_at(k + LAT, 4'd3, 1'b0, "recap_after_low");
    strobe_off();
    wait_until(k + LAT + 2);

`ifdef MNASSER_MULT_DEBOUNCE_EN
    // One-cycle glitch must not count as a strobe (state WAIT_B, A=3 shown)
    op_in = {1'b1, 5'd12};
    c = cyc;
    step(1);
    op_in[5] = 1'b0;
    expect_at(c + LAT + 1, 4'd3, 1'b0, "glitch_nocap");
    expect_at(c + LAT + 8, 4'd3, 1'b0, "glitch_nocap2");
    wait_until(c + LAT + 9);
`endif

    begin
      int guard;
      guard = 0;
      while (q.size() > 0 && guard < 200) begin
        step(1);
        guard++;
      end
      if (q.size() > 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain: %0d checks still pending, required 0", q.size());
      end
    end
    step(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
